// File: rtl/gray_pkg.sv
// gray_pkg: shared definitions for the Gray-code link.
//   - receiver state encodings (UNLOCKED, TRACK, ERROR)
//   - default code width
//   - 3-bit Gray sequence constants G0..G7, shared by the counter and the benches
//   - is_single_bit(): true when exactly one bit of a (zero-extended) vector is set
package gray_pkg;

  localparam int GRAY_WIDTH = 3;

  typedef enum logic [1:0] {
    UNLOCKED = 2'b00,
    TRACK    = 2'b01,
    ERROR    = 2'b10
  } gray_state_e;

  localparam logic [2:0] G0 = 3'b000;
  localparam logic [2:0] G1 = 3'b001;
  localparam logic [2:0] G2 = 3'b011;
  localparam logic [2:0] G3 = 3'b010;
  localparam logic [2:0] G4 = 3'b110;
  localparam logic [2:0] G5 = 3'b111;
  localparam logic [2:0] G6 = 3'b101;
  localparam logic [2:0] G7 = 3'b100;

  // A legal Gray advance flips exactly one bit: non-zero, and clearing the
  // lowest set bit leaves nothing behind.
  function automatic logic is_single_bit(input logic [7:0] d);
    return (d != 8'd0) && ((d & (d - 8'd1)) == 8'd0);
  endfunction

endpackage

// File: rtl/gray2bin.sv
// gray2bin: combinational Gray-to-binary decoder.
//   Gray   in  WIDTH  Gray-coded value
//   Binary out WIDTH  decoded value: b[W-1]=g[W-1], b[i]=b[i+1]^g[i]
// Each output bit is written as the XOR of all Gray bits at or above it,
// which is the unrolled form of the decode chain.
module gray2bin #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] Gray,
  output logic [WIDTH-1:0] Binary
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign Binary[i] = ^Gray[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_rx.sv
// gray_rx: receive side of the Gray-code counter link.
// Samples GrayIn on Valid, decodes it, and checks every accepted change is a
// single forward step. All outputs are registered (one-cycle latency).
//   Clk     in   clock, rising edge
//   Reset   in   synchronous active-high reset, highest priority
//   Valid   in   sample strobe for GrayIn
//   GrayIn  in   WIDTH  Gray-coded count
//   Binary  out  WIDTH  decode of the last accepted code
//   Step    out  one-cycle pulse per accepted forward advance
//   Locked  out  high once a code has been captured, low after an error
//   Wrap    out  sticky, set on the advance from all-ones to zero
//   Error   out  sticky, set on an illegal transition (exit only via Reset)
module gray_rx
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Valid,
  input  logic [WIDTH-1:0] GrayIn,
  output logic [WIDTH-1:0] Binary,
  output logic             Step,
  output logic             Locked,
  output logic             Wrap,
  output logic             Error
);

  gray_state_e      state_r, state_nxt_s;
  logic [WIDTH-1:0] last_r, last_nxt_s;
  logic [WIDTH-1:0] binary_r, binary_nxt_s;
  logic             step_r, step_nxt_s;
  logic             locked_r, locked_nxt_s;
  logic             wrap_r, wrap_nxt_s;
  logic             error_r, error_nxt_s;

  logic [WIDTH-1:0] decoded_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] expected_s;
  logic             single_s;

  gray2bin #(.WIDTH(WIDTH)) u_decode (
    .Gray   (GrayIn),
    .Binary (decoded_s)
  );

  assign diff_s     = GrayIn ^ last_r;
  assign expected_s = binary_r + {{(WIDTH-1){1'b0}}, 1'b1};
  assign single_s   = is_single_bit(8'(diff_s));

  // Next-state and next-output decode for the lock/track/error FSM.
  always_comb begin
    state_nxt_s  = state_r;
    last_nxt_s   = last_r;
    binary_nxt_s = binary_r;
    step_nxt_s   = 1'b0;
    locked_nxt_s = locked_r;
    wrap_nxt_s   = wrap_r;
    error_nxt_s  = error_r;

    case (state_r)
      UNLOCKED: begin
        if (Valid) begin
          // Any first code is accepted as the starting point.
          last_nxt_s   = GrayIn;
          binary_nxt_s = decoded_s;
          locked_nxt_s = 1'b1;
          state_nxt_s  = TRACK;
        end else begin
          state_nxt_s  = UNLOCKED;
        end
      end
      TRACK: begin
        if (!Valid) begin
          state_nxt_s = TRACK;
        end else if (diff_s == {WIDTH{1'b0}}) begin
          // Repeated code: the counter simply did not advance.
          state_nxt_s = TRACK;
        end else if (single_s && (decoded_s == expected_s)) begin
          last_nxt_s   = GrayIn;
          binary_nxt_s = decoded_s;
          step_nxt_s   = 1'b1;
          if (binary_r == {WIDTH{1'b1}}) begin
            wrap_nxt_s = 1'b1;
          end else begin
            wrap_nxt_s = wrap_r;
          end
        end else begin
          // Backward single-bit step or multi-bit jump; last/Binary freeze.
          error_nxt_s  = 1'b1;
          locked_nxt_s = 1'b0;
          state_nxt_s  = ERROR;
        end
      end
      ERROR: begin
        state_nxt_s = ERROR;
      end
      default: begin
        // Unused encoding: fall back to a clean re-lock.
        state_nxt_s  = UNLOCKED;
        locked_nxt_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r  <= UNLOCKED;
      last_r   <= {WIDTH{1'b0}};
      binary_r <= {WIDTH{1'b0}};
      step_r   <= 1'b0;
      locked_r <= 1'b0;
      wrap_r   <= 1'b0;
      error_r  <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      last_r   <= last_nxt_s;
      binary_r <= binary_nxt_s;
      step_r   <= step_nxt_s;
      locked_r <= locked_nxt_s;
      wrap_r   <= wrap_nxt_s;
      error_r  <= error_nxt_s;
    end
  end

  assign Binary = binary_r;
  assign Step   = step_r;
  assign Locked = locked_r;
  assign Wrap   = wrap_r;
  assign Error  = error_r;

endmodule

// File: doc/gray_rx.md
Name: gray_rx

Overview:
- Receiving end of the 3-bit Gray-code counter interface. Samples a Gray-coded count on a valid strobe, decodes it to binary, and checks that every accepted change is a legal single-step forward advance.
- Reports wrap-around with a sticky flag, mirroring the counter's overflow, and flags protocol violations.
- Sits downstream of a Gray counter, typically across a registered link, as the decode and check stage.

Parameters:
- WIDTH, 3, width of the Gray code and binary output; legal range 2..8.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Valid  in  1  GrayIn is sampled on a rising edge only when Valid=1.
- GrayIn  in  WIDTH  Gray-coded count from the transmitter.
- Binary  out  WIDTH  registered binary decode of the last accepted code.
- Step  out  1  one-cycle pulse on each accepted forward advance.
- Locked  out  1  high once the first code is captured; low again after an error.
- Wrap  out  1  sticky; set on the advance from 2^WIDTH-1 to 0.
- Error  out  1  sticky; set on an illegal transition.

Behaviour:
- There is a single clock (Clk); Reset is synchronous and active-high.
- Reset has priority over everything else. On the edge where Reset=1: Binary=0, Step=0, Locked=0, Wrap=0, Error=0, internal last-code register=0, state=UNLOCKED.
- Every output is registered. A sample on edge N is reflected on the outputs immediately after edge N (one-cycle latency).
- Decode: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i]. All arithmetic is modulo 2^WIDTH.
- When Valid=0, all state holds and Step=0.
- Step defaults to 0 on every edge; it is 1 only in the cases stated below.
- State UNLOCKED, on Valid:
  - Capture GrayIn as the last code; Binary=decode(GrayIn); Locked=1; go to TRACK.
  - Any initial value is accepted. Step stays 0 and Wrap is not set.
- State TRACK, on Valid, with d = GrayIn ^ last:
  - d==0 (repeat; the counter was not enabled): hold everything, Step=0.
  - popcount(d)==1 and decode(GrayIn)==Binary+1: accept the sample. Update last and Binary; Step=1.
    - If Binary was 2^WIDTH-1 (so the new value is 0), also set Wrap=1. Wrap then stays 1 until Reset.
  - Any other change, including a single-bit backward step or a multi-bit jump:
    - Error=1, Locked=0, go to ERROR.
    - Binary and last hold their pre-error values; Step=0.
- State ERROR: Valid is ignored and all outputs hold. Only Reset exits, returning to UNLOCKED.
- Simultaneous Reset and Valid: Reset wins and the sample is discarded.
- Reset mid-sequence: the next Valid re-locks to whatever code arrives, with no error.
- Wrap and Error are independent. A wrap followed later by an error leaves both flags set.
- State encoding: UNLOCKED=2'b00, TRACK=2'b01, ERROR=2'b10. The unused code 2'b11 recovers to UNLOCKED on the next edge.

Decomposition:
- Shared package gray_pkg holds:
  - the state encodings (UNLOCKED, TRACK, ERROR);
  - the default WIDTH=3;
  - the 3-bit Gray sequence constants G0..G7 (000, 001, 011, 010, 110, 111, 101, 100), reused by the counter and by benches.
- Sub-module gray2bin: purely combinational, parameterised by WIDTH, implements the decode chain. It is instantiated once in gray_rx, and benches may reuse it as a reference model.

Test Plan:
- Reset, then Valid each cycle with 000, 001, 011, 010, 110, 111, 101, 100, 000:
  - Binary steps 0..7 then 0; Locked=1 from the first sample.
  - Step=1 on the eight advances (not on the first sample).
  - Wrap=1 only after the final 000; Error=0 throughout.
- After locking at 011: present 011 for 3 Valid cycles, then drop Valid for 2 cycles → Binary stays 2, Step=0, no error.
- Lock at 001, then present 010 (two-bit jump) → Error=1, Locked=0, Binary stays 1. Following Valid samples (011, 010) are ignored.
- Lock at 011 (Binary 2), then present 001 (single-bit backward step) → Error=1. Then assert Reset → all outputs 0. Then Valid with 110 → Locked=1, Binary=4, Error=0, Wrap=0.
- Wrap to 000 so Wrap=1, then present 011 → Wrap and Error are both 1.
- Apply Reset and Valid=1 with GrayIn=111 on the same edge → outputs 0, Locked=0. Then Valid with 111 on the next edge → Binary=5, Locked=1.
